// File: rtl/l2_tx_arbiter_if.sv
// l2_tx_arbiter_if: bundles the two frame-source handshakes and the MAC-side byte stream.
//   Source A (ARP):     ReqA, ValA, SoFA, EoFA, DataA[7:0] -> arbiter; ConfirmA <- arbiter
//   Source B (payload): ReqB, ValB, SoFB, EoFB, DataB[7:0] -> arbiter; ConfirmB <- arbiter
//   MAC side:           FrameOut, ValOut, SoFOut, EoFOut, DataOut[7:0] <- arbiter
//   Status:             GrantId (0=A, 1=B), Busy, TimeoutErr <- arbiter
// modport master is the arbiter's view; modport slave is the sources/MAC view.
interface l2_tx_arbiter_if;
  logic       ReqA;
  logic       ConfirmA;
  logic       ValA;
  logic       SoFA;
  logic       EoFA;
  logic [7:0] DataA;
  logic       ReqB;
  logic       ConfirmB;
  logic       ValB;
  logic       SoFB;
  logic       EoFB;
  logic [7:0] DataB;
  logic       FrameOut;
  logic       ValOut;
  logic       SoFOut;
  logic       EoFOut;
  logic [7:0] DataOut;
  logic       GrantId;
  logic       Busy;
  logic       TimeoutErr;

  modport master (
    input  ReqA, ValA, SoFA, EoFA, DataA,
    input  ReqB, ValB, SoFB, EoFB, DataB,
    output ConfirmA, ConfirmB,
    output FrameOut, ValOut, SoFOut, EoFOut, DataOut,
    output GrantId, Busy, TimeoutErr
  );

  modport slave (
    output ReqA, ValA, SoFA, EoFA, DataA,
    output ReqB, ValB, SoFB, EoFB, DataB,
    input  ConfirmA, ConfirmB,
    input  FrameOut, ValOut, SoFOut, EoFOut, DataOut,
    input  GrantId, Busy, TimeoutErr
  );
endinterface

// File: rtl/l2_tx_arbiter.sv
// l2_tx_arbiter: two-source round-robin arbiter for the byte-wide L2 transmit path.
// Grants one source at a time, forwards its bytes with one registered stage, enforces an
// inter-frame gap and aborts grants whose source stalls before SoF or during a frame.
// Ports:
//   Clk  - system clock, rising edge
//   Rst  - synchronous active-high reset
//   bus  - l2_tx_arbiter_if.master: source handshakes in, Confirm/MAC stream/status out
module l2_tx_arbiter #(
  parameter int unsigned IFG_CYCLES       = 24,
  parameter int unsigned START_TIMEOUT    = 64,
  parameter int unsigned MAX_FRAME_CYCLES = 4096
) (
  input logic             Clk,
  input logic             Rst,
  l2_tx_arbiter_if.master bus
);

  localparam logic [7:0]  StartLast = 8'(START_TIMEOUT - 1);
  localparam logic [7:0]  GapLast   = 8'(IFG_CYCLES - 1);
  localparam logic [15:0] FrameMax  = 16'(MAX_FRAME_CYCLES);

  typedef enum logic [1:0] {StIdle, StGrant, StXfer, StGap} state_e;

  state_e      state_q;
  logic        ptr_q;        // last granted source
  logic        gid_q;
  logic [1:0]  arm_q;        // [0]=A, [1]=B
  logic [7:0]  start_cnt_q;
  logic [7:0]  gap_cnt_q;
  logic [15:0] frame_cnt_q;
  logic        confirm_a_q, confirm_b_q;
  logic        frame_q, val_q, sof_q, eof_q, busy_q, terr_q;
  logic [7:0]  data_q;

  logic       elig_a, elig_b, pick;
  logic       s_val, s_sof, s_eof;
  logic [7:0] s_data;

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign elig_a = bus.ReqA & arm_q[0];
  assign elig_b = bus.ReqB & arm_q[1];

  always_comb begin
    pick = elig_b;
    if (elig_a && elig_b) begin
      pick = ~ptr_q;
    end
  end

  // Only the granted source's strobes reach the datapath.
  always_comb begin
    s_val  = gid_q ? bus.ValB  : bus.ValA;
    s_sof  = gid_q ? bus.SoFB  : bus.SoFA;
    s_eof  = gid_q ? bus.EoFB  : bus.EoFA;
    s_data = gid_q ? bus.DataB : bus.DataA;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b1;
      gid_q       <= 1'b0;
      arm_q       <= 2'b11;
      start_cnt_q <= 8'd0;
      gap_cnt_q   <= 8'd0;
      frame_cnt_q <= 16'd0;
      confirm_a_q <= 1'b0;
      confirm_b_q <= 1'b0;
      frame_q     <= 1'b0;
      val_q       <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      data_q      <= 8'd0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      val_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      data_q  <= 8'd0;
      frame_q <= 1'b0;
      terr_q  <= 1'b0;
      // Re-arm after an observed idle request; grant end below overrides this.
      if (!bus.ReqA) arm_q[0] <= 1'b1;
      if (!bus.ReqB) arm_q[1] <= 1'b1;

      unique case (state_q)
        StIdle: begin
          if (elig_a || elig_b) begin
            gid_q       <= pick;
            ptr_q       <= pick;
            busy_q      <= 1'b1;
            start_cnt_q <= 8'd0;
            state_q     <= StGrant;
          end
        end
        StGrant: begin
          confirm_a_q <= ~gid_q;
          confirm_b_q <= gid_q;
          if (s_val && s_sof) begin
            val_q       <= 1'b1;
            sof_q       <= 1'b1;
            eof_q       <= s_eof;
            data_q      <= s_data;
            frame_q     <= 1'b1;
            frame_cnt_q <= 16'd1;
            state_q     <= StXfer;
            if (s_eof) begin
              confirm_a_q  <= 1'b0;
              confirm_b_q  <= 1'b0;
              arm_q[gid_q] <= 1'b0;
              gap_cnt_q    <= 8'd0;
              state_q      <= StGap;
            end
          end else if (start_cnt_q >= StartLast) begin
            terr_q       <= 1'b1;
            confirm_a_q  <= 1'b0;
            confirm_b_q  <= 1'b0;
            arm_q[gid_q] <= 1'b0;
            gap_cnt_q    <= 8'd0;
            state_q      <= StGap;
          end else begin
            start_cnt_q <= sat8(start_cnt_q);
          end
        end
        StXfer: begin
          val_q   <= s_val;
          sof_q   <= s_val & s_sof;
          eof_q   <= s_val & s_eof;
          data_q  <= s_val ? s_data : 8'd0;
          frame_q <= 1'b1;
          if (s_val && s_eof) begin
            confirm_a_q  <= 1'b0;
            confirm_b_q  <= 1'b0;
            arm_q[gid_q] <= 1'b0;
            gap_cnt_q    <= 8'd0;
            state_q      <= StGap;
          end else if (frame_cnt_q >= FrameMax) begin
            // Abort: suppress the byte and the frame level, never fake an EoF.
            val_q        <= 1'b0;
            sof_q        <= 1'b0;
            data_q       <= 8'd0;
            frame_q      <= 1'b0;
            terr_q       <= 1'b1;
            confirm_a_q  <= 1'b0;
            confirm_b_q  <= 1'b0;
            arm_q[gid_q] <= 1'b0;
            gap_cnt_q    <= 8'd0;
            state_q      <= StGap;
          end else begin
            frame_cnt_q <= sat16(frame_cnt_q);
          end
        end
        StGap: begin
          if (gap_cnt_q >= GapLast) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= sat8(gap_cnt_q);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ConfirmA   = confirm_a_q;
  assign bus.ConfirmB   = confirm_b_q;
  assign bus.FrameOut   = frame_q;
  assign bus.ValOut     = val_q;
  assign bus.SoFOut     = sof_q;
  assign bus.EoFOut     = eof_q;
  assign bus.DataOut    = data_q;
  assign bus.GrantId    = gid_q;
  assign bus.Busy       = busy_q;
  assign bus.TimeoutErr = terr_q;

endmodule

// File: tb/tb_l2_tx_arbiter.sv
// Scoreboard bench for l2_tx_arbiter: source tasks push each byte they expect forwarded,
// a negedge monitor pops and compares whenever ValOut is high; directed checks cover grant
// timing, gap length, round-robin, both timeouts and reset mid-frame.
module tb_l2_tx_arbiter;
  logic Clk = 1'b0;
  logic Rst;

  l2_tx_arbiter_if bus();

  l2_tx_arbiter #(
    .IFG_CYCLES      (24),
    .START_TIMEOUT   (64),
    .MAX_FRAME_CYCLES(4096)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus.master)
  );

  always #5 Clk = ~Clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         frame_hi = 0;
  int         fh0;
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {15'd0, bus.ConfirmA, bus.ConfirmB, bus.FrameOut, bus.ValOut, bus.SoFOut,
                 bus.EoFOut, bus.GrantId, bus.Busy, bus.TimeoutErr, bus.DataOut}, 32'd0);
  endtask

  // Monitor: every presented byte must match the head of the scoreboard.
  always @(negedge Clk) begin
    if (bus.FrameOut === 1'b1) frame_hi++;
    if (bus.ValOut === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_byte: got sof=%0b eof=%0b data=0x%0h, expected no byte",
                 bus.SoFOut, bus.EoFOut, bus.DataOut);
      end else begin
        mon_e = exp_q.pop_front();
        check("byte", {22'd0, bus.SoFOut, bus.EoFOut, bus.DataOut}, {22'd0, mon_e});
        check("frame_with_val", {31'd0, bus.FrameOut}, 32'd1);
      end
    end
  end

  task automatic drive(input logic src, input logic v, input logic s, input logic e,
                       input logic [7:0] d);
    if (!src) begin
      bus.ValA = v; bus.SoFA = s; bus.EoFA = e; bus.DataA = d;
    end else begin
      bus.ValB = v; bus.SoFB = s; bus.EoFB = e; bus.DataB = d;
    end
  endtask

  task automatic wait_confirm(input logic src);
    int n = 0;
    while (((src ? bus.ConfirmB : bus.ConfirmA) !== 1'b1) && n < 200) begin
      tick();
      n++;
    end
    check(src ? "confirm_b_wait" : "confirm_a_wait",
          {31'd0, (src ? bus.ConfirmB : bus.ConfirmA)}, 32'd1);
  endtask

  // Sends n bytes base, base+1, ...; one Val=0 cycle is inserted before byte 'hole'.
  task automatic send_frame(input logic src, input int n, input logic [7:0] base,
                            input int hole);
    logic       s, e;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if (i == hole) begin
        drive(src, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
      end
      s = (i == 0);
      e = (i == n - 1);
      d = base + 8'(i);
      drive(src, 1'b1, s, e, d);
      exp_q.push_back({s, e, d});
      tick();
    end
    drive(src, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [7:0] d;
    Rst = 1'b1;
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    repeat (3) tick();
    check_all_zero("reset_outputs");

    // Test 1: single 60-byte ARP frame; junk on B must be ignored.
    Rst      = 1'b0;
    bus.ReqA = 1'b1;
    fh0      = frame_hi;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE);
    tick();
    check("t1_confirm_a_edge1", {31'd0, bus.ConfirmA}, 32'd0);
    check("t1_busy_gid_edge1", {30'd0, bus.Busy, bus.GrantId}, 32'b10);
    tick();
    check("t1_confirm_a_edge2", {31'd0, bus.ConfirmA}, 32'd1);
    send_frame(1'b0, 60, 8'h10, -1);
    check("t1_confirm_a_drop", {31'd0, bus.ConfirmA}, 32'd0);
    check("t1_eof_out", {31'd0, bus.EoFOut}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check("t1_frame_len", 32'(frame_hi - fh0), 32'd60);
    repeat (22) tick();
    check("t1_gap_busy_23", {31'd0, bus.Busy}, 32'd1);
    tick();
    check("t1_gap_idle_24", {31'd0, bus.Busy}, 32'd0);

    // Test 3: ReqA held 30 clocks past EoF -> no re-grant until it drops for a clock.
    repeat (6) tick();
    check("t3_no_regrant", {31'd0, bus.Busy}, 32'd0);
    bus.ReqA = 1'b0;
    tick();
    bus.ReqA = 1'b1;
    tick();
    check("t3_regrant_a", {30'd0, bus.Busy, bus.GrantId}, 32'b10);
    wait_confirm(1'b0);
    send_frame(1'b0, 5, 8'h40, 2);
    bus.ReqA = 1'b0;
    repeat (25) tick();
    check("t3_idle", {31'd0, bus.Busy}, 32'd0);

    // Test 2: simultaneous requests after reset, then round-robin.
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check_all_zero("reset2_outputs");
    bus.ReqA = 1'b1;
    bus.ReqB = 1'b1;
    tick();
    check("t2_tie_a_first", {30'd0, bus.Busy, bus.GrantId}, 32'b10);
    wait_confirm(1'b0);
    send_frame(1'b0, 8, 8'h60, -1);
    bus.ReqA = 1'b0;
    repeat (24) tick();
    check("t2_gap_before_b", {31'd0, bus.Busy}, 32'd0);
    tick();
    check("t2_grant_b", {30'd0, bus.Busy, bus.GrantId}, 32'b11);
    bus.ReqA = 1'b1;
    wait_confirm(1'b1);
    send_frame(1'b1, 10, 8'h80, 4);
    bus.ReqB = 1'b0;
    repeat (24) tick();
    check("t2_gap_before_a", {31'd0, bus.Busy}, 32'd0);
    tick();
    check("t2_rr_grant_a", {30'd0, bus.Busy, bus.GrantId}, 32'b10);

    // 1-byte frame from A, then a true tie (pointer = A) must go to B.
    wait_confirm(1'b0);
    send_frame(1'b0, 1, 8'hA5, -1);
    bus.ReqA = 1'b0;
    bus.ReqB = 1'b1;
    tick();
    bus.ReqA = 1'b1;
    repeat (24) tick();
    check("t4_tie_grant_b", {30'd0, bus.Busy, bus.GrantId}, 32'b11);

    // Test 4: B never sends SoF -> start timeout at grant+64.
    repeat (63) tick();
    check("t4_no_terr_63", {30'd0, bus.TimeoutErr, bus.ConfirmB}, 32'b01);
    tick();
    check("t4_terr_64", {29'd0, bus.TimeoutErr, bus.ConfirmB, bus.ValOut}, 32'b100);
    tick();
    check("t4_terr_pulse_end", {31'd0, bus.TimeoutErr}, 32'd0);
    bus.ReqB = 1'b0;
    repeat (23) tick();
    check("t4_gap_before_a", {31'd0, bus.Busy}, 32'd0);
    tick();
    check("t4_pending_a", {30'd0, bus.Busy, bus.GrantId}, 32'b10);

    // Test 5: A sends SoF then stalls -> frame timeout 4096 clocks after SoF.
    wait_confirm(1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h5A);
    exp_q.push_back({1'b1, 1'b0, 8'h5A});
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    bus.ReqA = 1'b0;
    repeat (4095) tick();
    check("t5_pre_timeout", {30'd0, bus.TimeoutErr, bus.FrameOut}, 32'b01);
    tick();
    check("t5_timeout", {27'd0, bus.TimeoutErr, bus.FrameOut, bus.ValOut, bus.EoFOut,
                         bus.ConfirmA}, 32'b10000);
    repeat (23) tick();
    check("t5_gap_busy", {31'd0, bus.Busy}, 32'd1);
    tick();
    check("t5_idle", {31'd0, bus.Busy}, 32'd0);

    // Test 6: reset at byte 20 of a B frame, ReqB still high at release.
    bus.ReqB = 1'b1;
    tick();
    check("t6_grant_b", {30'd0, bus.Busy, bus.GrantId}, 32'b11);
    wait_confirm(1'b1);
    for (int i = 0; i < 20; i++) begin
      d = 8'hC0 + 8'(i);
      drive(1'b1, 1'b1, (i == 0), 1'b0, d);
      exp_q.push_back({(i == 0), 1'b0, d});
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'hD4);
    Rst = 1'b1;
    tick();
    check_all_zero("t6_reset_mid_frame");
    Rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check("t6_regrant_b", {30'd0, bus.Busy, bus.GrantId}, 32'b11);
    wait_confirm(1'b1);
    send_frame(1'b1, 2, 8'hE0, -1);
    bus.ReqB = 1'b0;
    repeat (26) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/l2_tx_arbiter.md
Name: l2_tx_arbiter

Overview:
Shares the single byte-wide L2 transmit path between two frame generators: port A, the ARP reply generator, and port B, the payload/BFD frame generator. It takes each source's level request, grants one source at a time with a held confirm level, and muxes the granted source's byte stream onto the MAC-side outputs with one registered stage. It enforces a minimum inter-frame gap and recovers from sources that stall, whether before start of frame or during a frame.

Parameters:
IFG_CYCLES, 24, idle clocks forced between a granted frame's EoF and the next grant (legal 1..255).
START_TIMEOUT, 64, clocks allowed from grant to the first valid SoF byte (legal 2..255).
MAX_FRAME_CYCLES, 4096, clocks allowed from SoF to EoF (legal 64..65535).

Ports:
Clk  in  1  system clock; all logic on rising edge.
Rst  in  1  synchronous, active-high reset.
ReqA  in  1  ARP source request level.
ConfirmA  out  1  grant level to ARP source.
ValA, SoFA, EoFA  in  1 each  ARP byte valid / first byte / last byte.
DataA  in  8  ARP byte.
ReqB  in  1  payload source request level.
ConfirmB  out  1  grant level to payload source.
ValB, SoFB, EoFB  in  1 each  payload byte valid / first byte / last byte.
DataB  in  8  payload byte.
FrameOut  out  1  high from the first forwarded SoF byte through the EoF byte.
ValOut, SoFOut, EoFOut  out  1 each  muxed strobes to the MAC.
DataOut  out  8  muxed byte.
GrantId  out  1  0 = A, 1 = B; valid while Busy.
Busy  out  1  high in GRANT, XFER and GAP.
TimeoutErr  out  1  one-clock pulse on either timeout.

Behaviour:
- Reset (Rst=1 at an edge): state IDLE; all outputs 0; round-robin pointer = B, so A wins the first tie; ArmA = ArmB = 1; counters 0. Reset mid-frame truncates the frame immediately. No EoF is emitted for a frame cut by reset.
- Eligibility: a source is eligible when Req & Arm.
  - Arm clears when that source's grant ends, for any reason.
  - Arm sets again only after a clock in which Req = 0 is sampled.
  - This prevents a re-grant while a source holds its request after its frame (the ARP source keeps ReqA high for about 26 sync clocks after EoF).
- IDLE: if no source is eligible, stay. If exactly one is eligible, grant it. If both are eligible, grant the source not equal to the pointer. On the grant, set the pointer to the granted source, drive GrantId, raise Confirm of the granted source on the next clock, and go to GRANT.
- GRANT: Confirm held high; the start counter runs.
  - Granted Val & SoF seen: go to XFER and forward that byte.
  - Counter reaches START_TIMEOUT with no SoF: pulse TimeoutErr, drop Confirm, go to GAP.
- XFER: Confirm held high.
  - Every clock: ValOut <= Val, SoFOut <= Val & SoF, EoFOut <= Val & EoF, DataOut <= Val ? Data : 0 from the granted source. Latency is exactly 1 clock, and the granted source's gaps in Val are passed through unchanged.
  - The non-granted source's inputs are ignored entirely.
  - FrameOut is registered high with the SoF byte and low the clock after the EoF byte.
  - Granted Val & EoF: drop Confirm on the next clock and go to GAP.
  - Frame counter reaches MAX_FRAME_CYCLES: pulse TimeoutErr, force ValOut = 0 and FrameOut = 0 (no EoFOut), drop Confirm, go to GAP.
- GAP: all data outputs 0; count IFG_CYCLES clocks, then go to IDLE. The earliest next grant is IFG_CYCLES+1 clocks after the EoF byte was accepted.
- SoF while already in XFER: treated as data. Val & SoF & EoF in the same cycle is a 1-byte frame: forward it and go to GAP.
- Outputs not in XFER, and the unselected Confirm: always 0.
- Counters are 8/8/16 bits and saturate; they never wrap.

Test Plan:
1. After reset, ReqA=1; A sends a 60-byte frame -> ConfirmA rises 2 clocks after ReqA; DataOut equals DataA delayed 1 clock; FrameOut is high for 60 clocks; ConfirmA drops the clock after EoF.
2. ReqA and ReqB rise in the same clock after reset -> A is granted first. After A's EoF plus 24 gap clocks, B is granted. A then re-requests during B's frame -> A is granted after B's gap (round-robin).
3. ReqA is held high for 30 clocks past A's EoF with no other requester -> no second grant. ReqA is then deasserted for 1 clock and reasserted -> A is granted after the gap completes.
4. B is granted but never asserts SoF -> TimeoutErr pulses at grant+64; ConfirmB drops; no ValOut; the pending A is granted after 24 gap clocks.
5. A sends SoF and then stalls for 4096 clocks without EoF -> TimeoutErr pulses; ValOut and FrameOut drop with no EoFOut; the arbiter is back in IDLE after 24 clocks.
6. Rst is asserted at byte 20 of a B frame -> on the next clock all outputs are 0 and ConfirmB=0. ReqB is still high at reset release -> B is granted again, because Arm is re-set by reset.
